ysyx_22040127_ifetch: RTL and testbench
=======================================

// Module: ysyx_22040127_ifetch
// PURPOSE
//  Instruction-fetch stage feeding the decode stage. Owns the fetch PC and issues one
//  64-bit doubleword read per instruction to instruction memory over a valid/ready request
//  and valid-only response. Selects the 32-bit word by pc[2] and holds it in a one-entry
//  IF->ID register. Applies branch/jump redirects from decode and discards wrong-path fetches.
// PARAMETERS
//  RESET_PC   32'h80000000  first fetch address after reset
//  PC_W       32            PC / address width
// PORTS
//  clk              in   1      clock
//  rst              in   1      synchronous reset, active-high
//  imem_req_valid   out  1      read request valid
//  imem_req_ready   in   1      memory accepts request this cycle
//  imem_req_addr    out  PC_W   {fetch_pc[PC_W-1:3],3'b000}, doubleword aligned
//  imem_resp_valid  in   1      read data valid (exactly one per accepted request)
//  imem_resp_data   in   64     aligned doubleword
//  redirect_valid   in   1      decode resolves taken branch/jump this cycle
//  redirect_pc      in   PC_W   redirect target
//  id_allowin       in   1      decode can accept this cycle
//  if_to_id_valid   out  1      IF->ID entry valid and not being flushed
//  if_to_id_bus     out  64     {inst[31:0], pc[31:0]}
// BEHAVIOUR
//  Reset (sync, high): fetch_pc=RESET_PC; state=REQ; out_valid=0; if_to_id_bus=0;
//   imem_req_valid=0 in the reset cycle. Reset wins over every other input.
//   Reset mid-operation drops any in-flight response; no DROP state after reset.
//  out_free = !out_valid || (if_to_id_valid && id_allowin).
//  FSM:
//   REQ : imem_req_valid = out_free && !redirect_valid.
//         On handshake -> WAIT, latch req_pc=fetch_pc.
//   WAIT: wait for imem_resp_valid. inst = req_pc[2] ? data[63:32] : data[31:0].
//         Load out reg {inst,req_pc}; out_valid<=1; fetch_pc<=req_pc+4; -> REQ.
//         A response arriving when out_valid=1 and ID is not consuming cannot occur
//         (requests issue only when out_free); the bench flags it as an error.
//   DROP: wait for the stale response, discard it, -> REQ.
//  Redirect (redirect_valid=1), priority over normal flow:
//   fetch_pc<=redirect_pc & ~1 (bit0 cleared); out_valid<=0.
//   WAIT with no response this cycle -> DROP.
//   WAIT with response this cycle -> response discarded, -> REQ.
//   DROP -> stays DROP. REQ -> REQ; no request is issued this cycle.
//   redirect_pc[1]=1 is passed through; decode raises the misalign fault.
//  if_to_id_valid = out_valid && !redirect_valid: the wrong-path entry never handshakes.
//  ID handshake (if_to_id_valid && id_allowin) clears out_valid unless it is reloaded in
//   the same cycle.
//  Latency: request handshake in cycle N, response in N+k (k>=1), valid to ID in N+k+1.
//   Zero-wait memory with ID always ready gives 1 instruction per 2 cycles.
//   Only one request is outstanding.
//  PC arithmetic: modulo 2^PC_W; 32'hFFFFFFFC + 4 wraps to 0 with no flag.
//  imem_req_addr is stable while imem_req_valid=1 && !imem_req_ready (redirect suppresses
//   valid, so no change occurs under a pending request).
// TESTING
//  1 Reset release, memory always ready, 1-cycle response, ID ready:
//    addrs 0x80000000,0x80000000,0x80000008; bus pc 0x80000000,0x80000004,0x80000008.
//  2 resp data 64'h00100073_00000013, pc=0x80000004 -> inst=0x00100073.
//    pc=0x80000000 -> inst=0x00000013.
//  3 id_allowin=0 for 5 cycles with out_valid=1: bus held, no new request.
//    Release: next request in the same cycle the handshake fires.
//  4 redirect to 0x80000100 while WAIT, response 3 cycles later:
//    response dropped, next request addr 0x80000100, no wrong-path valid to ID.
//  5 redirect in the same cycle as out_valid=1 and id_allowin=1:
//    if_to_id_valid=0 that cycle, and the next delivered pc is redirect_pc.
//  6 rst asserted in WAIT: following cycle state=REQ, pc=RESET_PC, stale response ignored.

Source files
------------

// File: rtl/ysyx_22040127_ifetch.sv
// Instruction fetch: owns the fetch PC, issues one doubleword read per instruction and
// holds the selected 32-bit word in a one-entry IF->ID register.
module ysyx_22040127_ifetch #(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [63:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            id_allowin,
  output logic            if_to_id_valid,
  output logic [63:0]     if_to_id_bus
);

  typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            out_valid_q, out_valid_d;
  logic [63:0]     out_bus_q, out_bus_d;

  logic            id_fire;
  logic            out_free;
  logic            req_fire;
  logic [31:0]     inst;
  logic [PC_W-1:0] redirect_target;

  // A redirected entry is wrong-path, so it must never handshake with decode.
  assign if_to_id_valid  = out_valid_q && !redirect_valid;
  assign if_to_id_bus    = out_bus_q;
  assign id_fire         = if_to_id_valid && id_allowin;
  assign out_free        = !out_valid_q || id_fire;

  assign imem_req_valid  = !rst && (state_q == StReq) && out_free && !redirect_valid;
  assign imem_req_addr   = {fetch_pc_q[PC_W-1:3], 3'b000};
  assign req_fire        = imem_req_valid && imem_req_ready;

  assign inst            = req_pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];
  assign redirect_target = {redirect_pc[PC_W-1:1], 1'b0};

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    out_valid_d = out_valid_q;
    out_bus_d   = out_bus_q;

    if (id_fire) begin
      out_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      fetch_pc_d  = redirect_target;
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StReq: begin
        if (req_fire) begin
          state_d  = StWait;
          req_pc_d = fetch_pc_q;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          // A response in the redirect cycle is the wrong-path one and is simply dropped.
          state_d = imem_resp_valid ? StReq : StDrop;
        end else if (imem_resp_valid) begin
          state_d     = StReq;
          out_valid_d = 1'b1;
          out_bus_d   = {inst, 32'(req_pc_q)};
          fetch_pc_d  = req_pc_q + PC_W'(4);
        end
      end
      StDrop: begin
        if (imem_resp_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StReq;
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= RESET_PC;
      out_valid_q <= 1'b0;
      out_bus_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      out_valid_q <= out_valid_d;
      out_bus_q   <= out_bus_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040127_ifetch.sv
// Directed bench for the fetch stage: a per-cycle vector table followed by a short
// sequence against a memory that answers with varying latency.
module tb_ysyx_22040127_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [63:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_allowin;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_bus;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22040127_ifetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .id_allowin      (id_allowin),
    .if_to_id_valid  (if_to_id_valid),
    .if_to_id_bus    (if_to_id_bus)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [63:0] data;
    logic        xv;
    logic [31:0] xpc;
    logic        id;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_toid;
    logic [63:0] e_bus;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic rdy, input logic rv, input logic [63:0] d,
                     input logic xv, input logic [31:0] xpc, input logic id,
                     input logic e_req, input logic [31:0] e_addr, input logic e_toid,
                     input logic [63:0] e_bus);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.data = d; v.xv = xv; v.xpc = xpc; v.id = id;
    v.e_req = e_req; v.e_addr = e_addr; v.e_toid = e_toid; v.e_bus = e_bus;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A response must never land while the output entry is occupied and not draining.
  always @(negedge clk) begin
    if (rst === 1'b0 && imem_resp_valid && if_to_id_valid && !id_allowin) begin
      errors++;
      $display("FAIL resp_into_full_entry: response arrived while IF->ID entry blocked");
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] hi, lo;
    int n;

    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_allowin = 1'b1;

    //   rst rdy rv data                    xv xpc           id  req addr          toid bus
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000000, 0, 64'h0);
    add(0, 1, 1, 64'h00100073_00000013,   0, 32'h0,        1,  0, 32'h80000000, 0, 64'h0);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000000, 1, 64'h00000013_80000000);
    add(0, 1, 1, 64'h00100073_00000013,   0, 32'h0,        1,  0, 32'h80000000, 0, 64'h00000013_80000000);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000008, 1, 64'h00100073_80000004);
    add(0, 1, 1, 64'hAAAA0001_BBBB0002,   0, 32'h0,        1,  0, 32'h80000008, 0, 64'h00100073_80000004);
    for (int i = 0; i < 5; i++)
      add(0, 1, 0, 64'h0,                 0, 32'h0,        0,  0, 32'h80000008, 1, 64'hBBBB0002_80000008);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000008, 1, 64'hBBBB0002_80000008);
    add(0, 1, 1, 64'hAAAA0001_BBBB0002,   0, 32'h0,        1,  0, 32'h80000008, 0, 64'hBBBB0002_80000008);
    // Redirect while an entry is offered to decode; bit 0 of the target is cleared.
    add(0, 1, 0, 64'h0,                   1, 32'h80000041, 1,  0, 32'h80000010, 0, 64'hAAAA0001_8000000C);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000040, 0, 64'hAAAA0001_8000000C);
    // Redirect during WAIT, stale response three cycles later.
    add(0, 1, 0, 64'h0,                   1, 32'h80000100, 1,  0, 32'h80000040, 0, 64'hAAAA0001_8000000C);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  0, 32'h80000100, 0, 64'hAAAA0001_8000000C);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  0, 32'h80000100, 0, 64'hAAAA0001_8000000C);
    add(0, 1, 1, 64'h11111111_22222222,   0, 32'h0,        1,  0, 32'h80000100, 0, 64'hAAAA0001_8000000C);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000100, 0, 64'hAAAA0001_8000000C);
    add(0, 1, 1, 64'h33333333_44444444,   0, 32'h0,        1,  0, 32'h80000100, 0, 64'hAAAA0001_8000000C);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000100, 1, 64'h44444444_80000100);
    // Redirect and response in the same WAIT cycle.
    add(0, 1, 1, 64'h55555555_66666666,   1, 32'h80000300, 1,  0, 32'h80000100, 0, 64'h44444444_80000100);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000300, 0, 64'h44444444_80000100);
    // Reset in WAIT; the stale response afterwards is ignored, address held while not ready.
    add(1, 1, 0, 64'h0,                   0, 32'h0,        1,  0, 32'h80000300, 0, 64'h44444444_80000100);
    add(0, 0, 1, 64'h77777777_88888888,   0, 32'h0,        1,  1, 32'h80000000, 0, 64'h0);
    add(0, 0, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000000, 0, 64'h0);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000000, 0, 64'h0);
    add(0, 1, 1, 64'h9999AAAA_BBBBCCCC,   0, 32'h0,        1,  0, 32'h80000000, 0, 64'h0);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h80000000, 1, 64'hBBBBCCCC_80000000);
    // PC wrap at the top of the address space.
    add(0, 1, 0, 64'h0,                   1, 32'hFFFFFFFD, 1,  0, 32'h80000000, 0, 64'hBBBBCCCC_80000000);
    add(0, 1, 1, 64'h0,                   0, 32'h0,        1,  0, 32'hFFFFFFF8, 0, 64'hBBBBCCCC_80000000);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'hFFFFFFF8, 0, 64'hBBBBCCCC_80000000);
    add(0, 1, 1, 64'hDEADBEEF_12345678,   0, 32'h0,        1,  0, 32'hFFFFFFF8, 0, 64'hBBBBCCCC_80000000);
    add(0, 1, 0, 64'h0,                   0, 32'h0,        1,  1, 32'h00000000, 1, 64'hDEADBEEF_FFFFFFFC);

    // Reset state.
    @(posedge clk); #1;
    @(posedge clk); #1;
    #3;
    chk("reset req_valid", 64'(imem_req_valid), 64'd0);
    chk("reset req_addr", 64'(imem_req_addr), 64'h80000000);
    chk("reset to_id_valid", 64'(if_to_id_valid), 64'd0);
    chk("reset bus", if_to_id_bus, 64'h0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; imem_req_ready = vecs[i].rdy; imem_resp_valid = vecs[i].rv;
      imem_resp_data = vecs[i].data; redirect_valid = vecs[i].xv; redirect_pc = vecs[i].xpc;
      id_allowin = vecs[i].id;
      #3;
      chk($sformatf("row%0d req_valid", i), 64'(imem_req_valid), 64'(vecs[i].e_req));
      chk($sformatf("row%0d req_addr", i), 64'(imem_req_addr), 64'(vecs[i].e_addr));
      chk($sformatf("row%0d to_id_valid", i), 64'(if_to_id_valid), 64'(vecs[i].e_toid));
      chk($sformatf("row%0d bus", i), if_to_id_bus, vecs[i].e_bus);
      @(posedge clk); #1;
    end

    // Sequential fetch with response latency 1..4 cycles.
    rst = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; redirect_valid = 1'b0;
    id_allowin = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc = 32'h80000000 + 32'(4 * i);
      n = 0;
      #3;
      while (!imem_req_valid && n < 10) begin
        @(posedge clk); #4;
        n++;
      end
      chk($sformatf("seq%0d req_seen", i), 64'(n < 10), 64'd1);
      chk($sformatf("seq%0d req_addr", i), 64'(imem_req_addr), 64'({pc[31:3], 3'b000}));
      @(posedge clk); #1;
      for (int k = 0; k < i; k++) begin
        @(posedge clk); #1;
      end
      hi = pc ^ 32'h0F0F0F0F;
      lo = ~pc;
      imem_resp_valid = 1'b1;
      imem_resp_data = {hi, lo};
      @(posedge clk); #1;
      imem_resp_valid = 1'b0;
      #3;
      chk($sformatf("seq%0d to_id_valid", i), 64'(if_to_id_valid), 64'd1);
      chk($sformatf("seq%0d bus", i), if_to_id_bus, {(pc[2] ? hi : lo), pc});
    end

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
